tl_ul_sram_responder: RTL and testbench

//  TL-UL single-beat responder (manager side) backed by a register-file memory.

---
 rtl/tl_ul_pkg.sv | 38 +++
 rtl/tl_resp_fifo.sv | 57 +++++
 rtl/tl_ul_sram_responder.sv | 135 +++++++++++++
 tb/tb_tl_ul_sram_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TL-UL opcodes, the D-channel response beat, and the byte-lane helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tl_ul_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  // One queued response; d_param and d_sink are constant and not stored
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [6:0]  source;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } d_beat_t;

  // Byte lanes a naturally aligned access of 2^size bytes at addr[2:0] may touch
  function automatic logic [7:0] size_lane_mask(input logic [2:0] size, input logic [2:0] addr);
    logic [7:0] lanes;
    case (size)
      3'd0:    lanes = 8'h01 << addr;
      3'd1:    lanes = 8'h03 << {addr[2:1], 1'b0};
      3'd2:    lanes = 8'h0F << {addr[2], 2'b00};
      3'd3:    lanes = 8'hFF;
      default: lanes = 8'h00;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/tl_resp_fifo.sv
// Flop-based FIFO holding D-channel responses in accept order.
// Latency: a push is visible on pop_dat/pop_vld the cycle after it is written.
// Backpressure: pushes are dropped when count==DEPTH; the caller gates on count.
module tl_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] slot [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_fire;
  logic             pop_fire;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_fire = push_vld && (count < CNT_W'(DEPTH));
  assign pop_vld   = (count != '0);
  assign pop_fire  = pop_vld && pop_rdy;
  assign pop_dat   = slot[rd_ptr];

  // Pointers and occupancy; reset empties the queue immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= next_ptr(wr_ptr);
      if (pop_fire)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge clock) begin
    if (push_fire) slot[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TL-UL single-beat manager backed by a DEPTH x 64-bit register-file memory.
// Latency: d_valid rises one cycle after accept when the response queue was empty.
// Backpressure: a_ready = queue not full (registered count only); d_* held until d_ready.
module tl_ul_sram_responder
  import tl_ul_pkg::*;
#(
  parameter logic [30:0] BASE_ADDR  = 31'h2000_0000,
  parameter int          DEPTH      = 64,
  parameter int          RESP_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [6:0]  a_source,
  input  logic [30:0] a_address,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_data,
  input  logic        a_corrupt,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [2:0]  d_size,
  output logic [6:0]  d_source,
  output logic        d_sink,
  output logic        d_denied,
  output logic [63:0] d_data,
  output logic        d_corrupt,
  output logic [15:0] denied_cnt
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam int          CNT_W = $clog2(RESP_DEPTH) + 1;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 8);

  logic [63:0]      mem [DEPTH];
  logic [30:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic             is_get;
  logic             is_put;
  logic             op_ok;
  logic             align_ok;
  logic             range_ok;
  logic             mask_ok;
  logic             denied;
  logic             accept;
  logic [CNT_W-1:0] fifo_count;
  d_beat_t          beat_in;
  d_beat_t          beat_out;
  logic             unused_param;

  assign unused_param = ^a_param;

  assign offset   = a_address - BASE_ADDR;
  assign word_idx = offset[IDX_W+2:3];
  assign is_get   = (a_opcode == GET);
  assign is_put   = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
  assign op_ok    = is_get || is_put;
  assign range_ok = (a_address >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign mask_ok  = (a_mask & ~size_lane_mask(a_size, a_address[2:0])) == 8'h00;
  assign denied   = !(op_ok && (a_size <= 3'd3) && align_ok && range_ok && mask_ok);

  assign a_ready  = (fifo_count < CNT_W'(RESP_DEPTH));
  assign accept   = a_valid && a_ready;

  // Natural alignment of the address to the access size
  always_comb begin
    align_ok = 1'b0;
    case (a_size)
      3'd0:    align_ok = 1'b1;
      3'd1:    align_ok = (a_address[0] == 1'b0);
      3'd2:    align_ok = (a_address[1:0] == 2'b00);
      3'd3:    align_ok = (a_address[2:0] == 3'b000);
      default: align_ok = 1'b0;
    endcase
  end

  // Build the response beat; Get data is the word as it stood before this edge.
  // Arithmetic/Logical (2,3) would be data-returning ops, so they get AccessAckData too.
  always_comb begin
    beat_in        = '0;
    beat_in.opcode = (is_get || a_opcode == 3'd2 || a_opcode == 3'd3) ? ACK_DATA : ACK;
    beat_in.size   = a_size;
    beat_in.source = a_source;
    beat_in.denied = denied;
    beat_in.data   = (is_get && !denied) ? mem[word_idx] : 64'h0;
    beat_in.corrupt = (beat_in.opcode == ACK_DATA) ? denied : 1'b0;
  end

  // Byte-masked write on accept; poisoned Put data is dropped silently
  always_ff @(posedge clock) begin
    if (accept && is_put && !denied && !a_corrupt) begin
      for (int b = 0; b < 8; b++) begin
        if (a_mask[b]) mem[word_idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  // Saturating count of rejected requests
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      denied_cnt <= '0;
    end else if (accept && denied && denied_cnt != 16'hFFFF) begin
      denied_cnt <= denied_cnt + 16'd1;
    end
  end

  tl_resp_fifo #(
    .WIDTH ($bits(d_beat_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push_vld (accept),
    .push_dat (beat_in),
    .pop_rdy  (d_ready),
    .pop_vld  (d_valid),
    .pop_dat  (beat_out),
    .count    (fifo_count)
  );

  assign d_opcode  = beat_out.opcode;
  assign d_param   = 2'b00;
  assign d_size    = beat_out.size;
  assign d_source  = beat_out.source;
  assign d_sink    = 1'b0;
  assign d_denied  = beat_out.denied;
  assign d_data    = beat_out.data;
  assign d_corrupt = beat_out.corrupt;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed bench for tl_ul_sram_responder with hand-computed expected values.
// Latency: inputs driven 1 time unit after posedge, outputs sampled there too.
// Backpressure: d_ready driven explicitly per scenario.
module tb_tl_ul_sram_responder;

  localparam logic [30:0] BASE = 31'h2000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = 3'd0;
  logic [2:0]  a_param = 3'd0;
  logic [2:0]  a_size = 3'd0;
  logic [6:0]  a_source = 7'd0;
  logic [30:0] a_address = 31'd0;
  logic [7:0]  a_mask = 8'd0;
  logic [63:0] a_data = 64'd0;
  logic        a_corrupt = 1'b0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [6:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;
  logic [15:0] denied_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  tl_ul_sram_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH      (64),
    .RESP_DEPTH (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_opcode   (a_opcode),
    .a_param    (a_param),
    .a_size     (a_size),
    .a_source   (a_source),
    .a_address  (a_address),
    .a_mask     (a_mask),
    .a_data     (a_data),
    .a_corrupt  (a_corrupt),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .d_opcode   (d_opcode),
    .d_param    (d_param),
    .d_size     (d_size),
    .d_source   (d_source),
    .d_sink     (d_sink),
    .d_denied   (d_denied),
    .d_data     (d_data),
    .d_corrupt  (d_corrupt),
    .denied_cnt (denied_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one A beat and hold it until accepted (bounded)
  task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [6:0] src,
                      input logic [30:0] addr, input logic [7:0] mask, input logic [63:0] data,
                      input logic corrupt);
    int n;
    a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_corrupt = corrupt;
    n = 0;
    while (!a_ready && n < 20) begin
      tick();
      n++;
    end
    if (!a_ready) chk("a_ready_timeout", 64'd0, 64'd1);
    tick();
    a_valid = 1'b0;
  endtask

  // Wait for a D beat (bounded), compare every field, then consume it
  task automatic recv(input string tag, input logic [2:0] op, input logic [6:0] src,
                      input logic [2:0] size, input logic den, input logic [63:0] data,
                      input logic cor);
    int n;
    n = 0;
    while (!d_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".valid"}, 64'(d_valid), 64'd1);
    chk({tag, ".opcode"}, 64'(d_opcode), 64'(op));
    chk({tag, ".source"}, 64'(d_source), 64'(src));
    chk({tag, ".size"}, 64'(d_size), 64'(size));
    chk({tag, ".denied"}, 64'(d_denied), 64'(den));
    chk({tag, ".data"}, d_data, data);
    chk({tag, ".corrupt"}, 64'(d_corrupt), 64'(cor));
    chk({tag, ".param_sink"}, 64'({d_param, d_sink}), 64'd0);
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.d_valid", 64'(d_valid), 64'd0);
    chk("rst.denied_cnt", 64'(denied_cnt), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst.a_ready", 64'(a_ready), 64'd1);

    // PutFull then Get of the same word
    send(3'd0, 3'd3, 7'd5, BASE + 31'h8, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b0);
    recv("putfull", 3'd0, 7'd5, 3'd3, 1'b0, 64'h0, 1'b0);
    send(3'd4, 3'd3, 7'd6, BASE + 31'h8, 8'hFF, 64'h0, 1'b0);
    recv("get8", 3'd1, 7'd6, 3'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b0);

    // PutPartial over a known pattern
    send(3'd0, 3'd3, 7'd7, BASE + 31'h10, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    recv("fill10", 3'd0, 7'd7, 3'd3, 1'b0, 64'h0, 1'b0);
    send(3'd1, 3'd3, 7'd8, BASE + 31'h10, 8'h0F, 64'h1111_1111_2222_2222, 1'b0);
    recv("partial", 3'd0, 7'd8, 3'd3, 1'b0, 64'h0, 1'b0);
    send(3'd4, 3'd3, 7'd9, BASE + 31'h10, 8'hFF, 64'h0, 1'b0);
    recv("get10", 3'd1, 7'd9, 3'd3, 1'b0, 64'hAAAA_AAAA_2222_2222, 1'b0);

    // Denied: out of range, misaligned, lanes outside the access
    send(3'd4, 3'd3, 7'd10, BASE + 31'h200, 8'hFF, 64'h0, 1'b0);
    recv("oor", 3'd1, 7'd10, 3'd3, 1'b1, 64'h0, 1'b1);
    chk("oor.cnt", 64'(denied_cnt), 64'd1);
    send(3'd4, 3'd2, 7'd11, BASE + 31'h2, 8'h0F, 64'h0, 1'b0);
    recv("misalign", 3'd1, 7'd11, 3'd2, 1'b1, 64'h0, 1'b1);
    chk("misalign.cnt", 64'(denied_cnt), 64'd2);
    send(3'd1, 3'd2, 7'd12, BASE + 31'hC, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    recv("badmask", 3'd0, 7'd12, 3'd2, 1'b1, 64'h0, 1'b0);
    chk("badmask.cnt", 64'(denied_cnt), 64'd3);

    // Poisoned Put: normal ack, word unchanged
    send(3'd0, 3'd3, 7'd13, BASE + 31'h8, 8'hFF, 64'h5555_5555_5555_5555, 1'b1);
    recv("poison", 3'd0, 7'd13, 3'd3, 1'b0, 64'h0, 1'b0);
    send(3'd4, 3'd3, 7'd14, BASE + 31'h8, 8'hFF, 64'h0, 1'b0);
    recv("poison.get", 3'd1, 7'd14, 3'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    chk("poison.cnt", 64'(denied_cnt), 64'd3);

    // Backpressure: queue of two fills, third request waits
    a_opcode = 3'd4; a_size = 3'd3; a_address = BASE + 31'h8; a_mask = 8'hFF; a_corrupt = 1'b0;
    a_valid = 1'b1; a_source = 7'd1;
    tick();
    chk("bp.valid1", 64'(d_valid), 64'd1);
    chk("bp.ready1", 64'(a_ready), 64'd1);
    a_source = 7'd2;
    tick();
    chk("bp.ready_full", 64'(a_ready), 64'd0);
    a_source = 7'd3;
    tick();
    chk("bp.hold_src", 64'(d_source), 64'd1);
    d_ready = 1'b1;
    #1;
    chk("bp.ready_with_dready", 64'(a_ready), 64'd0);
    tick();
    chk("bp.src2", 64'(d_source), 64'd2);
    chk("bp.ready_again", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    chk("bp.src3", 64'(d_source), 64'd3);
    tick();
    chk("bp.drained", 64'(d_valid), 64'd0);
    d_ready = 1'b0;

    // Back-to-back Gets with d_ready held: one response per cycle
    d_ready = 1'b1;
    a_valid = 1'b1;
    chk("b2b.idle", 64'(d_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      a_source = 7'(20 + i);
      tick();
      chk("b2b.valid", 64'(d_valid), 64'd1);
      chk("b2b.src", 64'(d_source), 64'(20 + i));
      chk("b2b.ready", 64'(a_ready), 64'd1);
    end
    a_valid = 1'b0;
    tick();
    chk("b2b.drained", 64'(d_valid), 64'd0);
    d_ready = 1'b0;

    // Reset with two responses queued
    send(3'd4, 3'd3, 7'd30, BASE + 31'h8, 8'hFF, 64'h0, 1'b0);
    send(3'd4, 3'd3, 7'd31, BASE + 31'h8, 8'hFF, 64'h0, 1'b0);
    chk("mid.queued", 64'(a_ready), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid.d_valid_async", 64'(d_valid), 64'd0);
    chk("mid.cnt_cleared", 64'(denied_cnt), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid.after_valid", 64'(d_valid), 64'd0);
    chk("mid.after_ready", 64'(a_ready), 64'd1);
    send(3'd4, 3'd3, 7'd32, BASE + 31'h8, 8'hFF, 64'h0, 1'b0);
    recv("keep8", 3'd1, 7'd32, 3'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    send(3'd4, 3'd3, 7'd33, BASE + 31'h10, 8'hFF, 64'h0, 1'b0);
    recv("keep10", 3'd1, 7'd33, 3'd3, 1'b0, 64'hAAAA_AAAA_2222_2222, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
